// File: rtl/spi_master_fifo.sv
// spi_master_fifo: master-only SPI engine with TX/RX FIFOs, burst transfers and multiple slave selects
//   clk, rst (sync, active low); spe core enable; cpol/cpha/lsbfe/spr/ss_sel transfer setup
//   tx_data/tx_valid/tx_ready TX FIFO push; rx_data/rx_valid/rx_ready RX FIFO pop (first-word-fall-through)
//   busy, spif (frame done pulse), rx_ovf (sticky); sck/mosi/miso/ss_n serial port
module spi_master_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS = 4,
  parameter int PrescalarWidth = 3,
  localparam int SW = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spe,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      lsbfe,
  input  logic [PrescalarWidth-1:0] spr,
  input  logic [SW-1:0]             ss_sel,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      busy,
  output logic                      spif,
  output logic                      rx_ovf,
  output logic                      sck,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_SS-1:0]         ss_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (1 << PrescalarWidth) - 1;
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_nx, rx_word, head;
  logic [CW:0] hp, hp_term;
  logic [EW-1:0] ec;
  logic [NUM_SS-1:0] ss_dec;
  logic [PrescalarWidth-1:0] spr_q;
  logic cpol_q, cpha_q, lsbfe_q, go, tx_empty, tx_full, rx_full;
  logic tick, start, load, lead, last, sample, shift, done, tx_push, rx_push, rx_pop, lsb_e, cpha_e;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic l);
    return l ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] d, input logic l);
    return l ? d >> 1 : d << 1;
  endfunction

  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = tx_wp == {~tx_rp[AW], tx_rp[AW-1:0]};
  assign rx_full  = rx_wp == {~rx_rp[AW], rx_rp[AW-1:0]};
  assign tx_ready = !tx_full;
  assign rx_valid = rx_wp != rx_rp;
  assign rx_data  = rx_valid ? rx_mem[rx_rp[AW-1:0]] : '0;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_pop   = rx_valid && rx_ready;
  assign busy     = state != IDLE;
  assign hp_term  = ((CW + 1)'(1) << spr_q) - (CW + 1)'(1);
  assign tick     = hp == hp_term;
  // go adds one cycle of arming in IDLE so the first SETUP follows a push by two edges
  assign start    = state == IDLE && go && spe && !tx_empty;
  assign load     = start || (state == GAP && spe && tick && !tx_empty);
  assign lead     = !ec[0];
  assign last     = ec == LAST;
  assign sample   = cpha_q ? !lead : lead;
  assign shift    = cpha_q ? lead : !lead && !last;
  assign done     = state == XFER && spe && tick && last;
  assign rx_push  = done && (!rx_full || rx_pop);
  // setup fields are latched on the same edge as the first load, so use the live inputs then
  assign lsb_e    = state == IDLE ? lsbfe : lsbfe_q;
  assign cpha_e   = state == IDLE ? cpha : cpha_q;
  assign head     = tx_mem[tx_rp[AW-1:0]];
  assign rx_nx    = lsbfe_q ? {miso, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso};
  // with cpha=1 the final edge is also a sample edge, so the last bit bypasses the shifter
  assign rx_word  = sample ? rx_nx : rx_sr;

  always_comb begin
    ss_dec = '0;
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = ss_sel == SW'(i);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_word;
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      tx_wp <= tx_wp + (AW + 1)'(tx_push);
      tx_rp <= tx_rp + (AW + 1)'(load);
      rx_wp <= rx_wp + (AW + 1)'(rx_push);
      rx_rp <= rx_rp + (AW + 1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    spif <= 1'b0;
    if (!rst) begin
      state  <= IDLE;
      go     <= 1'b0;
      sck    <= cpol;
      mosi   <= 1'b0;
      ss_n   <= '1;
      rx_ovf <= 1'b0;
      hp     <= '0;
      ec     <= '0;
    end else begin
      rx_ovf <= spe && (rx_ovf || (done && rx_full && !rx_pop));
      hp     <= (state == IDLE || tick) ? '0 : hp + 1'b1;
      if (busy && !spe) begin
        state <= IDLE;
        sck   <= cpol_q;
        ss_n  <= '1;
        ec    <= '0;
      end else begin
        case (state)
          IDLE: begin
            sck <= cpol;
            go  <= spe && !tx_empty && !go;
            if (start) begin
              state   <= SETUP;
              cpol_q  <= cpol;
              cpha_q  <= cpha;
              lsbfe_q <= lsbfe;
              spr_q   <= spr;
              ss_n    <= ~ss_dec;
            end
          end
          SETUP: if (tick) state <= XFER;
          XFER: if (tick) begin
            sck <= ~sck;
            ec  <= ec + 1'b1;
            if (sample) rx_sr <= rx_nx;
            if (shift) begin
              mosi  <= first_bit(tx_sr, lsbfe_q);
              tx_sr <= shifted(tx_sr, lsbfe_q);
            end
            if (last) begin
              state <= GAP;
              spif  <= 1'b1;
              ec    <= '0;
            end
          end
          GAP: if (tick) state <= tx_empty ? HOLD : XFER;
          HOLD: if (tick) begin
            state <= IDLE;
            ss_n  <= '1;
          end
          default: state <= IDLE;
        endcase
        if (load) begin
          if (cpha_e) tx_sr <= head;
          else begin
            mosi  <= first_bit(head, lsb_e);
            tx_sr <= shifted(head, lsb_e);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed tests for spi_master_fifo (8-bit/4-SS and 16-bit/1-SS instances)
module tb_spi_master_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spe = 1'b0, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
  logic [2:0] spr = 3'd0;
  logic [1:0] ss_sel = 2'd0;
  logic [7:0] tx_data = 8'd0, rx_data;
  logic tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic busy, spif, rx_ovf, sck, mosi, miso;
  logic [3:0] ss_n;
  logic loop = 1'b1, miso_drv = 1'b0;
  logic spe1 = 1'b0, tx_valid1 = 1'b0, rx_ready1 = 1'b0;
  logic [15:0] tx_data1 = 16'd0, rx_data1;
  logic tx_ready1, rx_valid1, busy1, spif1, rx_ovf1, sck1, mosi1;
  logic [0:0] ss_n1;
  int errors = 0, checks = 0;
  int edges0 = 0, edges1 = 0, spifs0 = 0;
  logic sck_p, sck1_p;

  assign miso = loop ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_fifo u0 (
    .clk(clk), .rst(rst), .spe(spe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spr(spr),
    .ss_sel(ss_sel), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .spif(spif),
    .rx_ovf(rx_ovf), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  spi_master_fifo #(.DATA_WIDTH(16), .NUM_SS(1)) u1 (
    .clk(clk), .rst(rst), .spe(spe1), .cpol(1'b0), .cpha(1'b0), .lsbfe(1'b0), .spr(3'd0),
    .ss_sel(1'b0), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .busy(busy1), .spif(spif1),
    .rx_ovf(rx_ovf1), .sck(sck1), .mosi(mosi1), .miso(mosi1), .ss_n(ss_n1)
  );

  always @(negedge clk) begin
    if (sck !== sck_p) edges0++;
    sck_p = sck;
    if (sck1 !== sck1_p) edges1++;
    sck1_p = sck1;
    if (spif === 1'b1) spifs0++;
  end

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_wait tx_ready=%b expected=1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || busy1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b busy1=%b expected=0", nm, busy, busy1);
    end
  endtask

  task automatic wait_sck(input logic lvl);
    int n = 0;
    @(negedge clk);
    while (sck !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sck !== lvl) begin
      checks++;
      errors++;
      $display("FAIL sck_wait sck=%b expected=%b", sck, lvl);
    end
  endtask

  task automatic pop_check(input string nm, input logic [7:0] exp);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      errors++;
      $display("FAIL %s rx_valid=%b rx_data=%h expected=1/%h", nm, rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string nm);
    checks++;
    if ({sck, mosi, ss_n, busy, spif, rx_ovf, tx_ready, rx_valid} !== 11'b0_0_1111_0_0_0_1_0) begin
      errors++;
      $display("FAIL %s_ctrl sck=%b mosi=%b ss_n=%b busy=%b spif=%b rx_ovf=%b tx_ready=%b rx_valid=%b expected 0 0 1111 0 0 0 1 0",
               nm, sck, mosi, ss_n, busy, spif, rx_ovf, tx_ready, rx_valid);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_rx_data got=%h expected=00", nm, rx_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    checks++;
    if (ss_n1 !== 1'b1 || tx_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_wide ss_n1=%b tx_ready1=%b busy1=%b expected 1 1 0", ss_n1, tx_ready1, busy1);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    int e0, s0, nb = 0, n = 0;
    logic [7:0] got = 8'h00;
    logic prev;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe} = {1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 1'b1, 1'b1};
    apply_reset();
    e0 = edges0;
    s0 = spifs0;
    push(8'hA5);
    @(negedge clk);
    checks++;
    if (ss_n !== 4'hF) begin
      errors++;
      $display("FAIL mode0_ss_early ss_n=%b expected=1111", ss_n);
    end
    @(negedge clk);
    checks++;
    if (ss_n !== 4'b1011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mode0_ss_low ss_n=%b busy=%b expected=1011 1", ss_n, busy);
    end
    prev = sck;
    while (nb < 8 && n < 200) begin
      @(negedge clk);
      if (sck === 1'b1 && prev === 1'b0) begin
        got = {got[6:0], mosi};
        nb++;
      end
      prev = sck;
      n++;
    end
    wait_idle("mode0");
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL mode0_mosi got=%h expected=a5", got);
    end
    checks++;
    if (edges0 - e0 !== 16) begin
      errors++;
      $display("FAIL mode0_edges got=%0d expected=16", edges0 - e0);
    end
    checks++;
    if (spifs0 - s0 !== 1) begin
      errors++;
      $display("FAIL mode0_spif got=%0d expected=1", spifs0 - s0);
    end
    checks++;
    if (ss_n !== 4'hF || sck !== 1'b0) begin
      errors++;
      $display("FAIL mode0_end ss_n=%b sck=%b expected=1111 0", ss_n, sck);
    end
    pop_check("mode0_rx", 8'hA5);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mode0_pop rx_valid=%b expected=0", rx_valid);
    end
  endtask

  task automatic test_mode3();
    logic [7:0] pat = 8'h3C, tx = 8'h69, got = 8'h00;
    time t_fall = 0, t_rise = 0;
    logic [3:0] ss_seen = 4'h0;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe, miso_drv} = {1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    checks++;
    if (sck !== 1'b1) begin
      errors++;
      $display("FAIL mode3_idle sck=%b expected=1", sck);
    end
    push(tx);
    for (int i = 0; i < 8; i++) begin
      wait_sck(1'b0);
      if (i == 0) begin
        t_fall = $time;
        ss_seen = ss_n;
      end
      got[i] = mosi;
      miso_drv = pat[i];
      wait_sck(1'b1);
      if (i == 0) t_rise = $time;
    end
    wait_idle("mode3");
    checks++;
    if (got[0] !== tx[0]) begin
      errors++;
      $display("FAIL mode3_bit0 mosi=%b expected=%b", got[0], tx[0]);
    end
    checks++;
    if (got !== tx) begin
      errors++;
      $display("FAIL mode3_mosi got=%h expected=%h", got, tx);
    end
    checks++;
    if (t_rise - t_fall !== 40) begin
      errors++;
      $display("FAIL mode3_halfperiod got=%0t expected=40", t_rise - t_fall);
    end
    checks++;
    if (ss_seen !== 4'b1110 || sck !== 1'b1) begin
      errors++;
      $display("FAIL mode3_ss ss_n=%b sck_end=%b expected=1110 1", ss_seen, sck);
    end
    pop_check("mode3_rx", 8'h3C);
  endtask

  task automatic test_back_to_back();
    int s0, n = 0, bad = 0;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe} = {1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b1};
    apply_reset();
    s0 = spifs0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    while (busy && n < 2000) begin
      if (ss_n !== 4'b1101) bad++;
      @(negedge clk);
      n++;
    end
    wait_idle("burst");
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL burst_ss got=%0d cycles with ss_n!=1101 expected=0", bad);
    end
    checks++;
    if (spifs0 - s0 !== 3) begin
      errors++;
      $display("FAIL burst_spif got=%0d expected=3", spifs0 - s0);
    end
    pop_check("burst_rx0", 8'h11);
    pop_check("burst_rx1", 8'h22);
    pop_check("burst_rx2", 8'h33);
  endtask

  task automatic test_overflow();
    int k = 0, n = 0;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe, rx_ready} = {1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_tx_full tx_ready=%b busy=%b expected=0 0", tx_ready, busy);
    end
    spe = 1'b1;
    push(8'd5);
    while ((busy || k == 0) && n < 3000) begin
      @(negedge clk);
      if (spif === 1'b1) begin
        k++;
        checks++;
        if (rx_ovf !== (k == 5)) begin
          errors++;
          $display("FAIL ovf_flag frame=%0d rx_ovf=%b expected=%b", k, rx_ovf, k == 5);
        end
      end
      n++;
    end
    wait_idle("ovf");
    checks++;
    if (k !== 5 || rx_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end frames=%0d rx_ovf=%b expected=5 1", k, rx_ovf);
    end
    for (int i = 1; i <= 4; i++) pop_check("ovf_rx", 8'(i));
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_count rx_valid=%b expected=0", rx_valid);
    end
    spe = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear rx_ovf=%b expected=0", rx_ovf);
    end
  endtask

  task automatic test_abort();
    int s0, ne = 0, n = 0;
    logic prev;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe} = {1'b0, 1'b0, 1'b0, 3'd1, 2'd3, 1'b1, 1'b1};
    apply_reset();
    s0 = spifs0;
    push(8'hC3);
    push(8'h5A);
    prev = sck;
    while (ne < 7 && n < 300) begin
      @(negedge clk);
      if (sck !== prev) ne++;
      prev = sck;
      n++;
    end
    spe = 1'b0;
    @(negedge clk);
    checks++;
    if (sck !== 1'b0 || ss_n !== 4'hF || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state sck=%b ss_n=%b busy=%b expected=0 1111 0", sck, ss_n, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (spifs0 !== s0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_rx spif=%0d rx_valid=%b expected=0 0", spifs0 - s0, rx_valid);
    end
    spe = 1'b1;
    wait_idle("abort");
    checks++;
    if (spifs0 - s0 !== 1) begin
      errors++;
      $display("FAIL abort_resume_spif got=%0d expected=1", spifs0 - s0);
    end
    pop_check("abort_kept", 8'h5A);
  endtask

  task automatic test_reset_mid();
    int s0;
    {cpol, cpha, lsbfe, spr, ss_sel, loop, spe} = {1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b1};
    apply_reset();
    s0 = spifs0;
    push(8'hF0);
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy busy=%b expected=1", busy);
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (spifs0 !== s0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after spif=%0d rx_valid=%b busy=%b expected=0 0 0", spifs0 - s0, rx_valid, busy);
    end
  endtask

  task automatic test_wide();
    int e1;
    spe = 1'b0;
    apply_reset();
    spe1 = 1'b1;
    e1 = edges1;
    @(negedge clk);
    tx_data1 = 16'hBEEF;
    tx_valid1 = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ss_n1 !== 1'b0) begin
      errors++;
      $display("FAIL wide_ss ss_n1=%b expected=0", ss_n1);
    end
    wait_idle("wide");
    checks++;
    if (edges1 - e1 !== 32) begin
      errors++;
      $display("FAIL wide_edges got=%0d expected=32", edges1 - e1);
    end
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data1 !== 16'hBEEF || ss_n1 !== 1'b1) begin
      errors++;
      $display("FAIL wide_rx rx_valid1=%b rx_data1=%h ss_n1=%b expected=1 beef 1", rx_valid1, rx_data1, ss_n1);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
